// File: rtl/if_spi_slave_if.sv
// if_spi_slave_if: SPI pins plus RX write / TX show-ahead read FIFO ports of the SPI responder
interface if_spi_slave_if;
  logic       n_cs;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic       tx_empty;
  logic       tx_rdreq;
  logic [7:0] rx_data;
  logic       rx_wrreq;
  logic       frame_done;
  logic       frame_err;
  logic       tx_underrun;
  modport slave (
    input  n_cs, sclk, mosi, tx_data, tx_empty,
    output miso, miso_oe, tx_rdreq, rx_data, rx_wrreq, frame_done, frame_err, tx_underrun
  );
  modport master (
    output n_cs, sclk, mosi, tx_data, tx_empty,
    input  miso, miso_oe, tx_rdreq, rx_data, rx_wrreq, frame_done, frame_err, tx_underrun
  );
endinterface

// File: rtl/if_spi_slave.sv
// if_spi_slave: oversampled SPI responder, MSB-first, with FIFO-style RX write and show-ahead TX read ports
module if_spi_slave #(
  parameter logic       CPOL            = 1'b0,
  parameter logic       CPHA            = 1'b0,
  parameter logic [7:0] BYTES_PER_FRAME = 8'd2,
  parameter logic [7:0] FILL_BYTE       = 8'h00
) (
  input logic           sys_clk,
  input logic           n_rst,
  if_spi_slave_if.slave io_spi
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t     r_state, w_next;
  logic [2:0] r_cs, r_sck;
  logic [1:0] r_mo;
  logic       r_warm, r_armed;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_byte_cnt;
  logic [6:0] r_rx_shift;
  logic [7:0] r_tx_byte, r_rx_data;
  logic       r_miso, r_oe, r_rx_wrreq, r_tx_rdreq, r_tx_underrun, r_frame_done, r_frame_err;
  logic       w_cs_fall, w_cs_rise, w_sck_edge, w_lead, w_trail;
  logic       w_start, w_end, w_smp, w_shf, w_byte_done, w_load, w_good;
  logic [7:0] w_load_byte;
  // bit 0 = sync stage 1, bit 1 = sync stage 2, bit 2 = history
  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cs    <= 3'b111;
      r_sck   <= {3{CPOL}};
      r_mo    <= 2'b00;
      r_warm  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_cs    <= {r_cs[1:0], io_spi.n_cs};
      r_sck   <= {r_sck[1:0], io_spi.sclk};
      r_mo    <= {r_mo[0], io_spi.mosi};
      r_warm  <= 1'b1;
      r_armed <= r_armed | (r_warm & (&r_cs));
    end
  end
  // a frame may only start once n_cs has really been seen high after reset
  assign w_cs_fall   = r_armed & ~r_cs[1] & r_cs[2];
  assign w_cs_rise   = r_cs[1] & ~r_cs[2];
  assign w_sck_edge  = r_sck[1] ^ r_sck[2];
  assign w_lead      = w_sck_edge & (r_sck[2] == CPOL);
  assign w_trail     = w_sck_edge & (r_sck[1] == CPOL);
  assign w_load_byte = io_spi.tx_empty ? FILL_BYTE : io_spi.tx_data;
  assign w_good      = (r_bit_cnt == 3'd0) && (r_byte_cnt == BYTES_PER_FRAME);
  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_start     = (r_state == IDLE) & w_cs_fall;
    w_end       = (r_state == ACTIVE) & w_cs_rise;
    w_smp       = (r_state == ACTIVE) & ~w_cs_rise & (CPHA ? w_trail : w_lead);
    w_shf       = (r_state == ACTIVE) & ~w_cs_rise & (CPHA ? w_lead : w_trail);
    w_byte_done = w_smp & (r_bit_cnt == 3'd7);
    w_load      = w_start | w_byte_done;
    w_next      = w_start ? ACTIVE : w_end ? IDLE : r_state;
  end
  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      r_bit_cnt     <= 3'd0;
      r_byte_cnt    <= 8'd0;
      r_rx_shift    <= 7'd0;
      r_tx_byte     <= 8'd0;
      r_rx_data     <= 8'd0;
      r_miso        <= 1'b0;
      r_oe          <= 1'b0;
      r_rx_wrreq    <= 1'b0;
      r_tx_rdreq    <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_rx_wrreq    <= w_byte_done;
      r_tx_rdreq    <= w_load & ~io_spi.tx_empty;
      r_tx_underrun <= w_load & io_spi.tx_empty;
      r_frame_done  <= w_end & w_good;
      r_frame_err   <= w_end & ~w_good;
      if (w_load) r_tx_byte <= w_load_byte;
      if (w_start) begin
        r_bit_cnt  <= 3'd0;
        r_byte_cnt <= 8'd0;
        r_oe       <= 1'b1;
        r_miso     <= CPHA ? 1'b0 : w_load_byte[7];
      end
      if (w_end) begin
        r_oe   <= 1'b0;
        r_miso <= 1'b0;
      end
      if (w_smp) begin
        r_rx_shift <= {r_rx_shift[5:0], r_mo[1]};
        r_bit_cnt  <= r_bit_cnt + 3'd1;
      end
      if (w_byte_done) begin
        r_rx_data <= {r_rx_shift, r_mo[1]};
        if (r_byte_cnt != 8'hFF) r_byte_cnt <= r_byte_cnt + 8'd1;
      end
      // bit index 7-bit_cnt covers both phases and the fresh byte after a boundary
      if (w_shf) r_miso <= r_tx_byte[~r_bit_cnt];
    end
  end
  assign io_spi.miso        = r_miso;
  assign io_spi.miso_oe     = r_oe;
  assign io_spi.rx_data     = r_rx_data;
  assign io_spi.rx_wrreq    = r_rx_wrreq;
  assign io_spi.tx_rdreq    = r_tx_rdreq;
  assign io_spi.tx_underrun = r_tx_underrun;
  assign io_spi.frame_done  = r_frame_done;
  assign io_spi.frame_err   = r_frame_err;
endmodule

// File: tb/tb_if_spi_slave.sv
// tb_if_spi_slave: mode-0 and mode-3 responders driven by a bit-banged master, scoreboard on RX and frame status
module tb_if_spi_slave;
  localparam int H = 4;
  logic sys_clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 sys_clk = ~sys_clk;
  if_spi_slave_if b0();
  if_spi_slave_if b1();
  if_spi_slave #(.CPOL(1'b0), .CPHA(1'b0), .BYTES_PER_FRAME(8'd2), .FILL_BYTE(8'hFF))
    u0 (.sys_clk(sys_clk), .n_rst(n_rst), .io_spi(b0));
  if_spi_slave #(.CPOL(1'b1), .CPHA(1'b1), .BYTES_PER_FRAME(8'd2), .FILL_BYTE(8'h96))
    u1 (.sys_clk(sys_clk), .n_rst(n_rst), .io_spi(b1));
  int checks = 0;
  int failures = 0;
  logic [7:0] mem [2][256];
  int wr [2];
  int mrd [2];
  int rd [2];
  int un [2];
  int un_exp [2];
  logic [7:0] exp_rx0[$], exp_rx1[$];
  logic exp_fs0[$], exp_fs1[$];
  assign b0.tx_empty = rd[0] >= wr[0];
  assign b0.tx_data  = mem[0][rd[0][7:0]];
  assign b1.tx_empty = rd[1] >= wr[1];
  assign b1.tx_data  = mem[1][rd[1][7:0]];
  always @(posedge sys_clk) begin
    if (b0.tx_rdreq) rd[0] <= rd[0] + 1;
    if (b1.tx_rdreq) rd[1] <= rd[1] + 1;
  end
  task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d got=%0h expected=%0h", nm, m, act, exp);
    end
  endtask
  task automatic mon(input int m, input logic w, input logic [7:0] d, input logic dn, input logic er);
    logic [7:0] e;
    logic f;
    if (w) begin
      if ((m == 0 ? exp_rx0.size() : exp_rx1.size()) == 0) chk("rx_unexpected", m, 1, 0);
      else begin
        if (m == 0) e = exp_rx0.pop_front();
        else e = exp_rx1.pop_front();
        chk("rx_data", m, {24'd0, d}, {24'd0, e});
      end
    end
    if (dn | er) begin
      chk("status_exclusive", m, {31'd0, dn & er}, 0);
      if ((m == 0 ? exp_fs0.size() : exp_fs1.size()) == 0) chk("status_unexpected", m, 1, 0);
      else begin
        if (m == 0) f = exp_fs0.pop_front();
        else f = exp_fs1.pop_front();
        chk("frame_done", m, {31'd0, dn}, {31'd0, f});
      end
    end
  endtask
  always @(negedge sys_clk) begin
    if (b0.tx_underrun) un[0]++;
    if (b1.tx_underrun) un[1]++;
    mon(0, b0.rx_wrreq, b0.rx_data, b0.frame_done, b0.frame_err);
    mon(1, b1.rx_wrreq, b1.rx_data, b1.frame_done, b1.frame_err);
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask
  task automatic pins(input int m, input logic cs, input logic sck, input logic mo);
    if (m == 0) begin
      b0.n_cs = cs; b0.sclk = sck; b0.mosi = mo;
    end else begin
      b1.n_cs = cs; b1.sclk = sck; b1.mosi = mo;
    end
  endtask
  function automatic logic miso_of(input int m);
    return m == 0 ? b0.miso : b1.miso;
  endfunction
  function automatic logic [1:0] pin_out(input int m);
    return m == 0 ? {b0.miso_oe, b0.miso} : {b1.miso_oe, b1.miso};
  endfunction
  function automatic logic [13:0] outs_of(input int m);
    return m == 0 ? {b0.miso, b0.miso_oe, b0.rx_data, b0.rx_wrreq, b0.tx_rdreq, b0.tx_underrun, b0.frame_done, b0.frame_err}
                  : {b1.miso, b1.miso_oe, b1.rx_data, b1.rx_wrreq, b1.tx_rdreq, b1.tx_underrun, b1.frame_done, b1.frame_err};
  endfunction
  task automatic push(input int m, input logic [7:0] v);
    mem[m][wr[m][7:0]] = v;
    wr[m]++;
  endtask
  // each frame performs one load per completed byte plus the initial one
  task automatic run_frame(input int m, input int nb, input int extra, input logic [31:0] d, input int gap, input bit abort);
    logic [7:0] ex [4];
    logic [7:0] rb;
    logic [7:0] fill;
    logic cp;
    logic b;
    int nbits;
    cp = (m == 1);
    fill = m == 0 ? 8'hFF : 8'h96;
    for (int s = 0; s <= nb; s++) begin
      if (mrd[m] < wr[m]) begin
        ex[s] = mem[m][mrd[m][7:0]];
        mrd[m]++;
      end else begin
        ex[s] = fill;
        un_exp[m]++;
      end
    end
    if (!abort) begin
      if (m == 0) exp_fs0.push_back(nb == 2 && extra == 0);
      else exp_fs1.push_back(nb == 2 && extra == 0);
    end
    pins(m, 1'b0, cp, 1'b0);
    cyc(H);
    chk("miso_oe_active", m, {31'd0, pin_out(m) >> 1}, 1);
    for (int j = 0; j <= nb; j++) begin
      nbits = j < nb ? 8 : extra;
      if (j < nb) begin
        if (m == 0) exp_rx0.push_back(d[31-8*j -: 8]);
        else exp_rx1.push_back(d[31-8*j -: 8]);
      end
      rb = 8'd0;
      for (int i = 0; i < nbits; i++) begin
        b = d[31-8*j-i];
        pins(m, 1'b0, 1'b0, b);
        cyc(H);
        rb[7-i] = miso_of(m);
        pins(m, 1'b0, 1'b1, b);
        cyc(H);
        if (!cp) pins(m, 1'b0, 1'b0, b);
      end
      if (j < nb) chk("master_rx", m, {24'd0, rb}, {24'd0, ex[j]});
    end
    if (abort) begin
      n_rst = 1'b0;
      cyc(2);
      chk("reset_outs", 0, {18'd0, outs_of(0)}, 0);
      chk("reset_outs", 1, {18'd0, outs_of(1)}, 0);
      pins(m, 1'b1, cp, 1'b0);
      cyc(3);
      n_rst = 1'b1;
      cyc(6);
    end else begin
      cyc(H);
      pins(m, 1'b1, cp, 1'b0);
      cyc(3);
      chk("miso_released", m, {30'd0, pin_out(m)}, 0);
      cyc(gap - 3);
    end
    chk("tx_pops", m, rd[m], mrd[m]);
    chk("underruns", m, un[m], un_exp[m]);
  endtask
  initial begin
    int m, nb, extra, nf;
    pins(0, 1'b1, 1'b0, 1'b0);
    pins(1, 1'b1, 1'b1, 1'b0);
    cyc(3);
    chk("reset_outs", 0, {18'd0, outs_of(0)}, 0);
    chk("reset_outs", 1, {18'd0, outs_of(1)}, 0);
    n_rst = 1'b1;
    cyc(5);
    for (int k = 0; k < 2; k++) begin
      push(k, 8'h5A); push(k, 8'hC3); push(k, 8'h11);
      run_frame(k, 2, 0, 32'hA53C0000, 6, 1'b0);
    end
    run_frame(0, 1, 0, {8'($urandom()), 24'd0}, 6, 1'b0);
    push(0, 8'h42);
    run_frame(0, 0, 5, 32'hB7000000, 6, 1'b0);
    push(0, 8'h6D);
    run_frame(0, 0, 3, 32'hE1000000, 6, 1'b1);
    push(0, 8'h24); push(0, 8'hDB);
    run_frame(0, 2, 0, 32'h817E0000, 6, 1'b0);
    for (int k = 0; k < 2; k++) begin
      for (int f = 0; f < 6; f++) push(k, 8'($urandom()));
      run_frame(k, 2, 0, $urandom(), 3, 1'b0);
      run_frame(k, 2, 0, $urandom(), 3, 1'b0);
    end
    repeat (14) begin
      m = $urandom_range(0, 1);
      nb = $urandom_range(0, 3);
      extra = $urandom_range(0, 3) == 0 ? $urandom_range(1, 7) : 0;
      nf = $urandom_range(0, 4);
      for (int f = 0; f < nf; f++) push(m, 8'($urandom()));
      run_frame(m, nb, extra, $urandom(), $urandom_range(3, 8), 1'b0);
    end
    cyc(20);
    chk("rx_pending", 0, exp_rx0.size(), 0);
    chk("rx_pending", 1, exp_rx1.size(), 0);
    chk("status_pending", 0, exp_fs0.size(), 0);
    chk("status_pending", 1, exp_fs1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
